// File: rtl/tseq_pkg.sv
// Shared types for the timer sequencer: FSM state encoding and mode encodings.
package tseq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tseq_state_e;

   localparam logic ONE_SHOT = 1'b0;
   localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/interval_counter.sv
// Interval count register: clear has priority over enable; never wraps by itself,
// the sequencer clears it at period-1.
module interval_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clear)       count_d = '0;
      else if (enable) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/timer_sequencer.sv
// One-shot / periodic interval timer with a cfg handshake accepted only in IDLE.
// Optional advance prescaler enabled by defining TSEQ_PRESCALER_EN.
module timer_sequencer
   import tseq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_period,
   input  logic             cfg_mode,
`ifdef TSEQ_PRESCALER_EN
   input  logic [7:0]       cfg_prescale,
`endif
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tick,
   output logic             done,
   output logic             err
);

   tseq_state_e      state_d, state_q;
   logic [WIDTH-1:0] period_d, period_q;
   logic             mode_d, mode_q;
   logic             cfg_load;
   logic             advance;
   logic             cnt_clear, cnt_en;

   assign cfg_ready = (state_q == IDLE);
   assign cfg_load  = cfg_valid && cfg_ready;

   always_comb begin
      period_d = period_q;
      mode_d   = mode_q;
      if (cfg_load) begin
         period_d = cfg_period;
         mode_d   = cfg_mode;
      end
   end

`ifdef TSEQ_PRESCALER_EN
   logic [7:0] prescale_d, prescale_q;
   logic [7:0] presc_cnt_d, presc_cnt_q;

   assign advance = (state_q == RUN) && (presc_cnt_q == prescale_q);

   // Prescaler sits at 0 outside RUN, so entry to RUN always starts a fresh phase.
   always_comb begin
      prescale_d  = cfg_load ? cfg_prescale : prescale_q;
      presc_cnt_d = '0;
      if (state_q == RUN && !stop && !advance)
         presc_cnt_d = presc_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale_q  <= '0;
         presc_cnt_q <= '0;
      end else begin
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
      end
   end
`else
   assign advance = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      busy      = 1'b0;
      tick      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clear = 1'b1;
            if (start && !stop) begin
               if (period_q != '0) state_d = RUN;
               else                err     = 1'b1;
            end
         end
         RUN: begin
            busy = 1'b1;
            // stop outranks a coincident interval end
            if (stop) begin
               state_d   = IDLE;
               cnt_clear = 1'b1;
            end else if (advance && count == period_q - WIDTH'(1)) begin
               tick      = 1'b1;
               cnt_clear = 1'b1;
               if (mode_q == ONE_SHOT) state_d = DONE;
            end else if (advance) begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            done      = 1'b1;
            cnt_clear = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         period_q <= '0;
         mode_q   <= ONE_SHOT;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         mode_q   <= mode_d;
      end
   end

   interval_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .count  (count)
   );

endmodule
